// File: rtl/asp_tx_retry_queue_if.sv
// Egress handshake bundle between the ASP network output and the network
// transmitter. The master drives words and ACKs; the slave (retry queue)
// drives the transmit strobe and the word in flight.
interface asp_tx_retry_queue_if #(
  parameter int width = 40
);
  logic             in_valid;
  logic [width-1:0] in_data_tag;
  logic             net_ack_in;
  logic             net_data_ready_out;
  logic [width-1:0] net_data_tag_out;

  modport master (
    output in_valid,
    output in_data_tag,
    output net_ack_in,
    input  net_data_ready_out,
    input  net_data_tag_out
  );

  modport slave (
    input  in_valid,
    input  in_data_tag,
    input  net_ack_in,
    output net_data_ready_out,
    output net_data_tag_out
  );
endinterface

// File: rtl/asp_tx_retry_queue.sv
// ASP network-egress retry queue: buffers tagged words, sends the head word,
// waits for an ACK and retransmits on timeout up to max_retries times. Words
// that exhaust their retries are dropped and counted (saturating).
//
// state    | meaning
// IDLE     | no word in flight; latch head word when the FIFO is non-empty
// SEND     | transmit strobe high for this one cycle
// WAIT_ACK | timing the ACK window; pop on ACK, retry or drop on timeout
module asp_tx_retry_queue #(
  parameter int data_size      = 32,
  parameter int tag_size       = 8,
  parameter int fifo_depth     = 8,
  parameter int timeout_cycles = 64,
  parameter int max_retries    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  asp_tx_retry_queue_if.slave     bus,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    overflow_out,
  output logic                    drop_out,
  output logic [15:0]             drop_count,
  output logic                    busy
);

  localparam int WORD_W = data_size + tag_size;
  localparam int PW     = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CW     = PW + 1;
  localparam int TW     = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam int RW     = (max_retries > 0) ? $clog2(max_retries + 1) : 1;

  localparam logic [CW-1:0] DEPTH  = CW'(fifo_depth);
  localparam logic [TW-1:0] T_LAST = TW'(timeout_cycles - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(max_retries);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t              state_q;
  logic [WORD_W-1:0]   mem_q [fifo_depth];
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [TW-1:0]       timer_q;
  logic [RW-1:0]       retry_q;
  logic [WORD_W-1:0]   tag_q;
  logic                ready_q;
  logic                ovf_q;
  logic                drop_q;
  logic [15:0]         drop_cnt_q;

  logic push;
  logic pop;
  logic acked;
  logic timed_out;
  logic give_up;

  // An ACK on the timeout edge wins over the timeout.
  assign acked     = (state_q == WAIT_ACK) && bus.net_ack_in;
  assign timed_out = (state_q == WAIT_ACK) && !bus.net_ack_in && (timer_q == T_LAST);
  assign give_up   = timed_out && (retry_q == R_MAX);
  assign pop       = acked || give_up;
  // Room is judged on the pre-edge count, so a same-cycle pop never frees a slot.
  assign push      = bus.in_valid && (count_q != DEPTH);

  // FIFO storage write; pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= bus.in_data_tag;
    end
  end

  // Queue bookkeeping, transmit FSM and registered status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      retry_q    <= '0;
      tag_q      <= '0;
      ready_q    <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ovf_q   <= bus.in_valid && (count_q == DEPTH);
      drop_q  <= give_up;
      ready_q <= 1'b0;

      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);

      if (give_up && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end

      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            tag_q   <= mem_q[rd_ptr_q];
            retry_q <= '0;
            ready_q <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          timer_q <= '0;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.net_ack_in) begin
            state_q <= IDLE;
          end else if (timer_q == T_LAST) begin
            if (retry_q != R_MAX) begin
              retry_q <= retry_q + RW'(1);
              ready_q <= 1'b1;
              state_q <= SEND;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.net_data_ready_out = ready_q;
  assign bus.net_data_tag_out   = tag_q;
  assign fifo_full              = (count_q == DEPTH);
  assign fifo_empty             = (count_q == '0);
  assign overflow_out           = ovf_q;
  assign drop_out               = drop_q;
  assign drop_count             = drop_cnt_q;
  assign busy                   = (state_q != IDLE);

endmodule
